// File: rtl/laser_vz_pkg.sv
`default_nettype none
// ============================================================================
//  laser_vz_pkg
//  Shared constants, state encoding and size helper for the VZ snapshot uploader.
//  Revision: 1.0
// ============================================================================
package laser_vz_pkg;

    localparam logic [31:0] VZ_MAGIC      = 32'h565A4630;  // "VZF0"
    localparam int          VZ_HDR_LEN    = 24;
    localparam int          VZ_NAME_LEN   = 17;
    localparam logic [7:0]  VZ_TYPE_BASIC = 8'hF0;
    localparam logic [7:0]  VZ_TYPE_BIN   = 8'hF1;

    typedef enum logic [2:0] {
        VZ_IDLE   = 3'd0,
        VZ_PTR_LO = 3'd1,
        VZ_PTR_HI = 3'd2,
        VZ_READY  = 3'd3,
        VZ_FETCH  = 3'd4
    } vz_state_t;

    // Header plus body; an empty or inverted range leaves only the header.
    function automatic logic [16:0] vz_image_size(input logic [15:0] start,
                                                  input logic [15:0] stop);
        logic [16:0] len;
        len = (stop > start) ? {1'b0, stop - start} : 17'd0;
        return 17'(VZ_HDR_LEN) + len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vz_header_rom.sv
`default_nettype none
// ============================================================================
//  vz_header_rom
//  Combinational lookup of the 24-byte .VZ header for a given byte offset.
//  Revision: 1.0
// ============================================================================
module vz_header_rom
    import laser_vz_pkg::*;
#(
    parameter logic [8*VZ_NAME_LEN-1:0] NAME_STR = "MISTER"
) (
    input  logic [4:0]  offset,
    input  logic [7:0]  img_type,
    input  logic [15:0] start,
    output logic [7:0]  hdr_byte
);

    function automatic int name_len(input logic [8*VZ_NAME_LEN-1:0] s);
        name_len = 0;
        for (int i = 0; i < VZ_NAME_LEN; i++) begin
            if (s[8*i +: 8] != 8'h00) name_len = i + 1;
        end
    endfunction

    // String parameters are right-aligned; the file format wants the name left-aligned.
    localparam logic [8*VZ_NAME_LEN-1:0] c_name =
        NAME_STR << (8 * (VZ_NAME_LEN - name_len(NAME_STR)));

    always_comb begin
        hdr_byte = 8'h00;
        case (offset)
            5'd0:    hdr_byte = VZ_MAGIC[31:24];
            5'd1:    hdr_byte = VZ_MAGIC[23:16];
            5'd2:    hdr_byte = VZ_MAGIC[15:8];
            5'd3:    hdr_byte = VZ_MAGIC[7:0];
            5'd21:   hdr_byte = img_type;
            5'd22:   hdr_byte = start[7:0];
            5'd23:   hdr_byte = start[15:8];
            default: begin
                for (int i = 0; i < VZ_NAME_LEN; i++) begin
                    if (offset == 5'(i + 4)) hdr_byte = c_name[8*(VZ_NAME_LEN-1-i) +: 8];
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vz_snapshot_uploader.sv
`default_nettype none
// ============================================================================
//  vz_snapshot_uploader
//  Builds a .VZ image of Laser310 RAM and serves it byte-wise to hps_io upload.
//  Option macro: VZ_UPLOAD_CPU_HOLD_EN (stall the Z80 for the whole upload).
//  Revision: 1.0
// ============================================================================
module vz_snapshot_uploader
    import laser_vz_pkg::*;
#(
    parameter int                       MEM_LAT     = 2,
    parameter logic [15:0]              BASIC_START = 16'h7AE9,
    parameter logic [15:0]              PTR_ADDR    = 16'h78F9,
    parameter logic [8*VZ_NAME_LEN-1:0] NAME_STR    = "MISTER"
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        snap_req,
    input  logic        bin_mode,
    input  logic [15:0] bin_start,
    input  logic [15:0] bin_end,
    output logic        up_active,
    input  logic        up_rd,
    input  logic [15:0] up_addr,
    output logic [7:0]  up_din,
    output logic        up_busy,
    output logic [16:0] up_size,
    output logic        up_done,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        cpu_hold
);

    localparam logic [2:0]  c_lat_last = 3'(MEM_LAT - 1);
    localparam logic [16:0] c_hdr_len  = 17'(VZ_HDR_LEN);

    vz_state_t   r_state, w_state_nxt;
    logic [15:0] r_start, r_mem_addr;
    logic [7:0]  r_type, r_ptr_lo, r_din;
    logic [16:0] r_size;
    logic [2:0]  r_cnt;
    logic        r_done, r_mem_rd, r_last;

    logic        w_lat_hit, w_issue, w_load, w_done;
    logic [15:0] w_issue_addr, w_body_addr;
    logic [7:0]  w_load_val, w_hdr_byte;
    logic [16:0] w_addr_ext;

    assign w_lat_hit   = (r_cnt == c_lat_last);
    assign w_addr_ext  = {1'b0, up_addr};
    assign w_body_addr = r_start + up_addr - 16'(VZ_HDR_LEN);

    vz_header_rom #(.NAME_STR(NAME_STR)) u_hdr (
        .offset   (up_addr[4:0]),
        .img_type (r_type),
        .start    (r_start),
        .hdr_byte (w_hdr_byte)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= VZ_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_addr = r_mem_addr;
        w_load       = 1'b0;
        w_load_val   = r_din;
        w_done       = 1'b0;
        case (r_state)
            VZ_IDLE: begin
                if (snap_req) begin
                    if (bin_mode) begin
                        w_state_nxt = VZ_READY;
                    end else begin
                        w_state_nxt  = VZ_PTR_LO;
                        w_issue      = 1'b1;
                        w_issue_addr = PTR_ADDR;
                    end
                end
            end
            VZ_PTR_LO: begin
                if (w_lat_hit) begin
                    w_state_nxt  = VZ_PTR_HI;
                    w_issue      = 1'b1;
                    w_issue_addr = PTR_ADDR + 16'd1;
                end
            end
            VZ_PTR_HI: begin
                if (w_lat_hit) w_state_nxt = VZ_READY;
            end
            VZ_READY: begin
                // r_done marks the last byte already served: leave instead of serving more.
                if (r_done) begin
                    w_state_nxt = VZ_IDLE;
                end else if (up_rd) begin
                    if (w_addr_ext < c_hdr_len) begin
                        w_load     = 1'b1;
                        w_load_val = w_hdr_byte;
                        w_done     = (w_addr_ext == r_size - 17'd1);
                    end else if (w_addr_ext < r_size) begin
                        w_state_nxt  = VZ_FETCH;
                        w_issue      = 1'b1;
                        w_issue_addr = w_body_addr;
                    end else begin
                        w_load     = 1'b1;
                        w_load_val = 8'h00;
                    end
                end
            end
            VZ_FETCH: begin
                if (w_lat_hit) begin
                    w_state_nxt = VZ_READY;
                    w_load      = 1'b1;
                    w_load_val  = mem_data;
                    w_done      = r_last;
                end
            end
            default: w_state_nxt = VZ_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_start    <= 16'h0000;
            r_mem_addr <= 16'h0000;
            r_type     <= 8'h00;
            r_ptr_lo   <= 8'h00;
            r_din      <= 8'h00;
            r_size     <= 17'd0;
            r_cnt      <= 3'd0;
            r_done     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_mem_rd <= w_issue;
            r_done   <= w_done;
            // Counter restarts on every read strobe and parks at the capture value.
            if (w_issue) begin
                r_mem_addr <= w_issue_addr;
                r_cnt      <= 3'd0;
            end else if (!w_lat_hit) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_load) r_din <= w_load_val;
            if (r_state == VZ_IDLE && snap_req) begin
                r_type  <= bin_mode ? VZ_TYPE_BIN : VZ_TYPE_BASIC;
                r_start <= bin_mode ? bin_start : BASIC_START;
                if (bin_mode) r_size <= vz_image_size(bin_start, bin_end);
            end
            if (r_state == VZ_PTR_LO && w_lat_hit) r_ptr_lo <= mem_data;
            if (r_state == VZ_PTR_HI && w_lat_hit) r_size <= vz_image_size(r_start, {mem_data, r_ptr_lo});
            if (r_state == VZ_READY && w_state_nxt == VZ_FETCH)
                r_last <= (w_addr_ext == r_size - 17'd1);
        end
    end

    assign up_active = (r_state == VZ_READY) || (r_state == VZ_FETCH);
    assign up_busy   = (r_state == VZ_FETCH);
    assign up_din    = r_din;
    assign up_size   = r_size;
    assign up_done   = r_done;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_mem_addr;

`ifdef VZ_UPLOAD_CPU_HOLD_EN
    assign cpu_hold = (r_state != VZ_IDLE);
`else
    assign cpu_hold = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vz_snapshot_uploader.sv
`default_nettype none
// ============================================================================
//  tb_vz_snapshot_uploader
//  Scoreboard bench: image bytes predicted from the file format, checked by a monitor.
//  Revision: 1.0
// ============================================================================
module tb_vz_snapshot_uploader;

    localparam int MEM_LAT = 2;
`ifdef VZ_UPLOAD_CPU_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic        clk_sys, reset, snap_req, bin_mode, up_rd;
    logic [15:0] bin_start, bin_end, up_addr, mem_addr;
    logic        up_active, up_busy, up_done, mem_rd, cpu_hold;
    logic [7:0]  up_din, mem_data;
    logic [16:0] up_size;

    vz_snapshot_uploader #(.MEM_LAT(MEM_LAT)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .snap_req  (snap_req),
        .bin_mode  (bin_mode),
        .bin_start (bin_start),
        .bin_end   (bin_end),
        .up_active (up_active),
        .up_rd     (up_rd),
        .up_addr   (up_addr),
        .up_din    (up_din),
        .up_busy   (up_busy),
        .up_size   (up_size),
        .up_done   (up_done),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cpu_hold  (cpu_hold)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // RAM: data for a read strobe is valid on the following cycle (MEM_LAT=2), junk otherwise.
    logic [7:0] ram [0:65535];
    always @(posedge clk_sys) mem_data <= mem_rd ? ram[mem_addr] : 8'($urandom);

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         addr;
        logic [7:0] val;
        logic       done;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_fail = 0, n_memrd = 0, exp_rd = 0;

    // Reference model of the current image
    bit          m_active = 1'b0;
    logic [15:0] m_start  = 16'h0000;
    logic [7:0]  m_type   = 8'h00;
    int          m_size   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] img_byte(input int a);
        string magic = "VZF0";
        string nm    = "MISTER";
        if (a < 4)   return magic[a];
        if (a < 21)  return (a - 4 < nm.len()) ? nm[a-4] : 8'h00;
        if (a == 21) return m_type;
        if (a == 22) return m_start[7:0];
        if (a == 23) return m_start[15:8];
        return ram[16'(int'(m_start) + a - 24)];
    endfunction

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (mem_rd) n_memrd++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk($sformatf("up_din offset %0d", sb[0].addr), {24'h0, up_din}, {24'h0, sb[0].val});
                chk($sformatf("up_done offset %0d", sb[0].addr), {31'h0, up_done}, {31'h0, sb[0].done});
                void'(sb.pop_front());
            end else begin
                if (up_done) chk("spurious up_done", {31'h0, up_done}, 32'h0);
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    chk("response overdue", cyc, sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic snap(input bit bin, input logic [15:0] s, input logic [15:0] e);
        bit accept;
        int n, e_i, s_i;
        accept = !m_active;
        @(posedge clk_sys); #1;
        snap_req = 1'b1; bin_mode = bin; bin_start = s; bin_end = e;
        @(posedge clk_sys); #1;
        snap_req = 1'b0; bin_mode = 1'($urandom); bin_start = 16'($urandom); bin_end = 16'($urandom);
        if (!accept) begin
            chk("ignored snap keeps up_size", {15'h0, up_size}, m_size);
            chk("ignored snap keeps up_active", {31'h0, up_active}, 32'h1);
            return;
        end
        chk("cpu_hold after snap_req", {31'h0, cpu_hold}, {31'h0, HOLD_EN});
        m_type  = bin ? 8'hF1 : 8'hF0;
        m_start = bin ? s : 16'h7AE9;
        e_i = bin ? int'(e) : int'({ram[16'h78FA], ram[16'h78F9]});
        s_i = int'(m_start);
        m_size = 24 + ((e_i > s_i) ? e_i - s_i : 0);
        if (!bin) exp_rd += 2;
        n = 0;
        while (!up_active && n < 40) begin @(posedge clk_sys); #1; n++; end
        chk("up_active rises", {31'h0, up_active}, 32'h1);
        chk("up_size", {15'h0, up_size}, m_size);
        chk("cpu_hold while active", {31'h0, cpu_hold}, {31'h0, HOLD_EN});
        m_active = 1'b1;
    endtask

    task automatic rd(input int a);
        exp_t x;
        bit   fetch;
        int   n;
        x = '{due: 0, addr: a, val: 8'h00, done: 1'b0};
        @(posedge clk_sys); #1;
        up_rd = 1'b1; up_addr = 16'(a);
        if (m_active) begin
            fetch  = (a >= 24 && a < m_size);
            x.due  = cyc + (fetch ? MEM_LAT + 1 : 1);
            x.val  = (a < m_size) ? img_byte(a) : 8'h00;
            x.done = (a == m_size - 1);
            sb.push_back(x);
            if (fetch) exp_rd++;
        end
        @(posedge clk_sys); #1;
        up_rd = 1'b0; up_addr = 16'($urandom);
        n = 0;
        while (up_busy && n < 20) begin @(posedge clk_sys); #1; n++; end
        if (n >= 20) chk("up_busy timeout", {31'h0, up_busy}, 32'h0);
        if (m_active && x.done) begin
            chk("up_active in done cycle", {31'h0, up_active}, 32'h1);
            @(posedge clk_sys); #1;
            chk("up_active falls after done", {31'h0, up_active}, 32'h0);
            chk("cpu_hold falls with up_active", {31'h0, cpu_hold}, 32'h0);
            m_active = 1'b0;
        end
    endtask

    // Second request is issued while the first is still fetching and must be dropped.
    task automatic rd_collide(input int a, input int b);
        exp_t x;
        int   n;
        @(posedge clk_sys); #1;
        up_rd = 1'b1; up_addr = 16'(a);
        x = '{due: cyc + MEM_LAT + 1, addr: a, val: img_byte(a), done: (a == m_size - 1)};
        sb.push_back(x);
        exp_rd++;
        @(posedge clk_sys); #1;
        up_addr = 16'(b);
        chk("up_busy during fetch", {31'h0, up_busy}, 32'h1);
        @(posedge clk_sys); #1;
        up_rd = 1'b0;
        n = 0;
        while (up_busy && n < 20) begin @(posedge clk_sys); #1; n++; end
        chk("collide: up_din is first request", {24'h0, up_din}, {24'h0, img_byte(a)});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " up_active"}, {31'h0, up_active}, 32'h0);
        chk({tag, " up_busy"},   {31'h0, up_busy},   32'h0);
        chk({tag, " up_done"},   {31'h0, up_done},   32'h0);
        chk({tag, " up_din"},    {24'h0, up_din},    32'h0);
        chk({tag, " up_size"},   {15'h0, up_size},   32'h0);
        chk({tag, " mem_rd"},    {31'h0, mem_rd},    32'h0);
        chk({tag, " mem_addr"},  {16'h0, mem_addr},  32'h0);
        chk({tag, " cpu_hold"},  {31'h0, cpu_hold},  32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, len, ptr;
        bit bin;
        reset = 1'b1; snap_req = 1'b0; bin_mode = 1'b0; bin_start = 16'h0; bin_end = 16'h0;
        up_rd = 1'b0; up_addr = 16'h0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        repeat (3) @(posedge clk_sys);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // BASIC image from the end-of-program pointer
        ram[16'h78F9] = 8'h10;
        ram[16'h78FA] = 8'h7B;
        snap(1'b0, 16'h0, 16'h0);
        chk("basic up_size", {15'h0, up_size}, 32'd63);
        for (int a = 0; a < 4; a++) rd(a);
        for (int a = 21; a < 24; a++) rd(a);
        chk("basic start hi byte", {24'h0, up_din}, 32'h7A);
        rd(24); rd(40); rd(70); rd(4);
        snap(1'b1, 16'h1000, 16'h1100);
        rd(21);
        rd(62);
        chk("mem_rd count basic", n_memrd, exp_rd);

        // Binary image, four body bytes
        ram[16'h8000] = 8'h11; ram[16'h8001] = 8'h22; ram[16'h8002] = 8'h33; ram[16'h8003] = 8'h44;
        snap(1'b1, 16'h8000, 16'h8004);
        chk("bin up_size", {15'h0, up_size}, 32'd28);
        for (int a = 24; a < 28; a++) rd(a);
        chk("bin last byte", {24'h0, up_din}, 32'h44);

        // Empty binary range: header only
        snap(1'b1, 16'h9000, 16'h9000);
        rd(30);
        chk("out-of-range byte", {24'h0, up_din}, 32'h0);
        rd(0); rd(1); rd(21);
        rd(23);
        chk("mem_rd count bin", n_memrd, exp_rd);

        // Colliding request, then reset in the middle of a fetch
        snap(1'b1, 16'hA000, 16'hA010);
        rd_collide(27, 2);
        rd(21);
        @(posedge clk_sys); #1;
        up_rd = 1'b1; up_addr = 16'd24;
        @(posedge clk_sys); #1;
        up_rd = 1'b0;
        chk("up_busy before reset", {31'h0, up_busy}, 32'h1);
        reset = 1'b1;
        #1;
        chk_all_zero("async reset");
        sb.delete();
        m_active = 1'b0;
        n_memrd = 0; exp_rd = 0;
        @(posedge clk_sys); #1;
        chk_all_zero("held reset");
        reset = 1'b0;
        repeat (6) @(posedge clk_sys);
        #1;
        chk("no up_done after reset", {31'h0, up_done}, 32'h0);

        // Randomized snapshots of both kinds
        for (int t = 0; t < 10; t++) begin
            bin = ($urandom_range(0, 2) != 0);
            if (bin) begin
                s   = $urandom_range(0, 65535);
                len = $urandom_range(0, 40);
                if (t == 3) snap(1'b1, 16'(s), 16'(s - 1));
                else        snap(1'b1, 16'(s), 16'(s + len));
            end else begin
                ptr = 'h7AE9 + $urandom_range(0, 45) - 5;
                ram[16'h78F9] = 8'(ptr);
                ram[16'h78FA] = 8'(ptr >> 8);
                snap(1'b0, 16'h0, 16'h0);
            end
            repeat (6) rd($urandom_range(0, m_size + 4));
            rd(m_size - 1);
        end
        chk("mem_rd count random", n_memrd, exp_rd);

        repeat (6) @(posedge clk_sys);
        #1;
        chk("scoreboard drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
